// File: rtl/demux_dispatch_ctrl.sv
// rtl/demux_dispatch_ctrl.sv - credit-gated dispatcher feeding the 4-way bus demux
//
// Accepts a valid/ready payload stream, picks a destination channel (explicit
// in_dest or round-robin), and registers the word and select toward the demux.
// Each channel owns a credit counter mirroring free space in its downstream
// buffer; a word is only accepted when its target channel has a credit.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_data      payload word
//   in_dest      explicit destination channel (ignored when in_rr=1)
//   in_rr        1 = round-robin destination, 0 = use in_dest
//   in_valid     payload valid
//   in_ready     combinational: target channel has a credit
//   y            registered data to demux
//   sel          registered channel select to demux
//   y_valid      one-cycle pulse per accepted word
//   ch_strobe    one-hot of sel while y_valid=1
//   credit_ret   per-channel credit return, one credit per set bit
//   credit_err   sticky: credit returned to an already-full channel
module demux_dispatch_ctrl #(
    parameter int BUS_WIDTH = 8,
    parameter int CREDITS   = 4,
    parameter int CW        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic [1:0]           in_dest,
    input  logic                 in_rr,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] y,
    output logic [1:0]           sel,
    output logic                 y_valid,
    output logic [3:0]           ch_strobe,
    input  logic [3:0]           credit_ret,
    output logic                 credit_err
);

    localparam logic [CW-1:0] CREDITS_CW = CW'(CREDITS);
    localparam logic [CW-1:0] ONE_CW     = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        credit_q [4];
    logic [CW-1:0]        credit_d [4];
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [BUS_WIDTH-1:0] y_q, y_d;
    logic [1:0]           sel_q, sel_d;
    logic                 err_q, err_d;

    logic [1:0]           target;
    logic                 accept;
    logic [3:0]           take;

    // Target is re-evaluated every cycle so in_rr may flip between words.
    // The round-robin pointer never skips an empty channel: it simply stalls.
    always_comb begin
        target   = in_rr ? rr_ptr_q : in_dest;
        in_ready = rst_n & (credit_q[target] != '0);
        accept   = in_valid & in_ready;
        take     = accept ? (4'b0001 << target) : 4'b0000;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? XFER : IDLE;
            XFER:    state_d = accept ? XFER : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        y_d      = y_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q;

        if (accept) begin
            y_d   = in_data;
            sel_d = target;
            if (in_rr) begin
                rr_ptr_d = rr_ptr_q + 2'd1;
            end
        end

        // A take and a return on the same channel cancel. A lone return to a
        // full channel is a protocol error from downstream; clamp and flag it.
        // Returns only affect credit_q next cycle, so they never bypass into
        // the current in_ready.
        for (int k = 0; k < 4; k++) begin
            credit_d[k] = credit_q[k];
            case ({take[k], credit_ret[k]})
                2'b10: credit_d[k] = credit_q[k] - ONE_CW;
                2'b01: begin
                    if (credit_q[k] == CREDITS_CW) begin
                        err_d = 1'b1;
                    end else begin
                        credit_d[k] = credit_q[k] + ONE_CW;
                    end
                end
                default: credit_d[k] = credit_q[k];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= 2'd0;
            y_q      <= '0;
            sel_q    <= 2'd0;
            err_q    <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                credit_q[k] <= CREDITS_CW;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            y_q      <= y_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
            for (int k = 0; k < 4; k++) begin
                credit_q[k] <= credit_d[k];
            end
        end
    end

    assign y          = y_q;
    assign sel        = sel_q;
    assign y_valid    = (state_q == XFER);
    assign ch_strobe  = (state_q == XFER) ? (4'b0001 << sel_q) : 4'b0000;
    assign credit_err = err_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb/tb_demux_dispatch_ctrl.sv - self-checking bench for demux_dispatch_ctrl
module tb_demux_dispatch_ctrl;

    localparam int CREDITS = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic       in_rr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] y;
    logic [1:0] sel;
    logic       y_valid;
    logic [3:0] ch_strobe;
    logic [3:0] credit_ret;
    logic       credit_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_credit [4];
    int         m_rr;
    logic [7:0] m_y;
    int         m_sel;
    bit         m_valid;
    bit         m_err;
    bit         m_ready;
    int         m_tgt;

    demux_dispatch_ctrl #(.BUS_WIDTH(8), .CREDITS(CREDITS), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest),
        .in_rr(in_rr), .in_valid(in_valid), .in_ready(in_ready), .y(y),
        .sel(sel), .y_valid(y_valid), .ch_strobe(ch_strobe),
        .credit_ret(credit_ret), .credit_err(credit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] exp_strobe();
        return m_valid ? (4'b0001 << m_sel) : 4'b0000;
    endfunction

    // Drive inputs just after a falling edge and predict in_ready.
    task automatic apply(input logic [7:0] d, input logic [1:0] dest, input logic rr,
                         input logic v, input logic [3:0] ret, input logic rstn_v);
        in_data    = d;
        in_dest    = dest;
        in_rr      = rr;
        in_valid   = v;
        credit_ret = ret;
        rst_n      = rstn_v;
        m_tgt      = rr ? m_rr : int'(dest);
        m_ready    = rstn_v && (m_credit[m_tgt] != 0);
        #1;
    endtask

    // Clock edge: advance the model from the rules, then settle at the falling edge.
    task automatic advance();
        bit acc, inc, dec;
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) m_credit[k] = CREDITS;
            m_rr = 0; m_valid = 0; m_y = 8'h00; m_sel = 0; m_err = 0;
        end else begin
            acc = in_valid && m_ready;
            for (int k = 0; k < 4; k++) begin
                inc = credit_ret[k];
                dec = acc && (m_tgt == k);
                if (inc && !dec) begin
                    if (m_credit[k] == CREDITS) m_err = 1;
                    else m_credit[k]++;
                end else if (dec && !inc) begin
                    m_credit[k]--;
                end
            end
            if (acc) begin
                m_y = in_data; m_sel = m_tgt; m_valid = 1;
                if (in_rr) m_rr = (m_rr + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply(8'h00, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        advance();
        apply(8'h00, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1);
    endtask

    task automatic test_reset();
        apply(8'hFF, 2'd3, 1'b0, 1'b1, 4'hF, 1'b0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready act=%b req=0", in_ready); end
        advance();
        total++; if (y !== 8'h00) begin bad++; $display("FAIL reset_y act=%h req=00", y); end
        total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel act=%0d req=0", sel); end
        total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL reset_y_valid act=%b req=0", y_valid); end
        total++; if (ch_strobe !== 4'b0000) begin bad++; $display("FAIL reset_strobe act=%b req=0000", ch_strobe); end
        total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_err act=%b req=0", credit_err); end
        apply(8'h00, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready act=%b req=1", in_ready); end
    endtask

    task automatic test_explicit();
        do_reset();
        apply(8'h5A, 2'd2, 1'b0, 1'b1, 4'h0, 1'b1);
        advance();
        apply(8'h00, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1);
        total++; if (y !== 8'h5A) begin bad++; $display("FAIL explicit_y act=%h req=5a", y); end
        total++; if (sel !== 2'd2) begin bad++; $display("FAIL explicit_sel act=%0d req=2", sel); end
        total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL explicit_valid act=%b req=1", y_valid); end
        total++; if (ch_strobe !== 4'b0100) begin bad++; $display("FAIL explicit_strobe act=%b req=0100", ch_strobe); end
        total++; if (dut.credit_q[2] !== 4'd3) begin bad++; $display("FAIL explicit_credit2 act=%0d req=3", dut.credit_q[2]); end
        advance();
        total++; if (y_valid !== 1'b0 || y !== 8'h5A) begin bad++; $display("FAIL explicit_hold act=%b/%h req=0/5a", y_valid, y); end
    endtask

    task automatic test_exhaust();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(8'(8'h10 + i), 2'd1, 1'b0, 1'b1, 4'h0, 1'b1);
            total++; if (in_ready !== (i < 4)) begin bad++; $display("FAIL exhaust_ready beat=%0d act=%b req=%b", i, in_ready, (i < 4)); end
            advance();
            total++; if (y_valid !== (i < 4)) begin bad++; $display("FAIL exhaust_valid beat=%0d act=%b req=%b", i, y_valid, (i < 4)); end
        end
        apply(8'h14, 2'd1, 1'b0, 1'b1, 4'b0010, 1'b1);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL exhaust_no_bypass act=%b req=0", in_ready); end
        advance();
        apply(8'h14, 2'd1, 1'b0, 1'b1, 4'h0, 1'b1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL exhaust_resume_ready act=%b req=1", in_ready); end
        advance();
        total++; if (y_valid !== 1'b1 || y !== 8'h14 || sel !== 2'd1) begin bad++; $display("FAIL exhaust_fifth act=%b/%h/%0d req=1/14/1", y_valid, y, sel); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(8'(i), 2'(3 - (i % 4)), 1'b1, 1'b1, 4'h0, 1'b1);
            advance();
            total++; if (sel !== 2'(i % 4) || y !== 8'(i) || ch_strobe !== (4'b0001 << (i % 4))) begin
                bad++; $display("FAIL rr_seq beat=%0d act=%0d/%h/%b req=%0d/%h", i, sel, y, ch_strobe, i % 4, i);
            end
        end
        for (int k = 0; k < 4; k++) begin
            total++; if (dut.credit_q[k] !== 4'd2) begin bad++; $display("FAIL rr_credit ch=%0d act=%0d req=2", k, dut.credit_q[k]); end
        end
    endtask

    task automatic test_rr_stall();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(8'(i), 2'd1, 1'b0, 1'b1, 4'h0, 1'b1);
            advance();
        end
        apply(8'hA0, 2'd0, 1'b1, 1'b1, 4'h0, 1'b1);
        advance();
        total++; if (sel !== 2'd0 || y_valid !== 1'b1) begin bad++; $display("FAIL stall_first act=%0d/%b req=0/1", sel, y_valid); end
        apply(8'hA1, 2'd3, 1'b1, 1'b1, 4'h0, 1'b1);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_noskip act=%b req=0", in_ready); end
        advance();
        apply(8'hA1, 2'd3, 1'b1, 1'b1, 4'b0010, 1'b1);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ret_cycle act=%b req=0", in_ready); end
        advance();
        apply(8'hA1, 2'd3, 1'b1, 1'b1, 4'h0, 1'b1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_resume_ready act=%b req=1", in_ready); end
        advance();
        total++; if (sel !== 2'd1 || y !== 8'hA1 || y_valid !== 1'b1) begin bad++; $display("FAIL stall_resume act=%0d/%h/%b req=1/a1/1", sel, y, y_valid); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(8'(8'h30 + i), 2'd0, 1'b0, 1'b1, 4'b0001, 1'b1);
            advance();
        end
        total++; if (dut.credit_q[0] !== 4'd4) begin bad++; $display("FAIL simul_credit0 act=%0d req=4", dut.credit_q[0]); end
        total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL simul_err act=%b req=0", credit_err); end
        apply(8'h00, 2'd0, 1'b0, 1'b0, 4'b1000, 1'b1);
        advance();
        total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL overflow_err act=%b req=1", credit_err); end
        for (int i = 0; i < 3; i++) begin
            apply(8'h00, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1);
            advance();
        end
        total++; if (credit_err !== 1'b1 || dut.credit_q[3] !== 4'd4) begin bad++; $display("FAIL overflow_sticky act=%b/%0d req=1/4", credit_err, dut.credit_q[3]); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(8'(8'h70 + i), 2'd0, 1'b1, 1'b1, 4'h0, 1'b1);
            advance();
        end
        apply(8'h7F, 2'd2, 1'b1, 1'b1, 4'hF, 1'b0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready act=%b req=0", in_ready); end
        advance();
        total++; if (y_valid !== 1'b0 || y !== 8'h00 || sel !== 2'd0) begin bad++; $display("FAIL midrst_out act=%b/%h/%0d req=0/00/0", y_valid, y, sel); end
        for (int k = 0; k < 4; k++) begin
            total++; if (dut.credit_q[k] !== 4'd4) begin bad++; $display("FAIL midrst_credit ch=%0d act=%0d req=4", k, dut.credit_q[k]); end
        end
        total++; if (dut.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL midrst_rr act=%0d req=0", dut.rr_ptr_q); end
    endtask

    task automatic test_random();
        logic [3:0] ret;
        logic       rstn_v;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ret = 4'h0;
            for (int k = 0; k < 4; k++) begin
                if (m_credit[k] < CREDITS) ret[k] = ($urandom_range(0, 2) == 0);
                else ret[k] = ($urandom_range(0, 40) == 0);
            end
            rstn_v = ($urandom_range(0, 80) != 0);
            apply(8'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), ret, rstn_v);
            total++; if (in_ready !== m_ready) begin bad++; $display("FAIL rand_ready cyc=%0d act=%b req=%b", i, in_ready, m_ready); end
            advance();
            total++; if (y_valid !== m_valid || ch_strobe !== exp_strobe() || y !== m_y || sel !== 2'(m_sel) || credit_err !== m_err) begin
                bad++;
                $display("FAIL rand_out cyc=%0d act=%b/%b/%h/%0d/%b req=%b/%b/%h/%0d/%b", i,
                         y_valid, ch_strobe, y, sel, credit_err, m_valid, exp_strobe(), m_y, m_sel, m_err);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_dest = '0; in_rr = 1'b0; in_valid = 1'b0; credit_ret = '0;
        for (int k = 0; k < 4; k++) m_credit[k] = CREDITS;
        m_rr = 0; m_y = 8'h00; m_sel = 0; m_valid = 0; m_err = 0; m_ready = 0; m_tgt = 0;
        @(negedge clk);
        test_reset();
        test_explicit();
        test_exhaust();
        test_round_robin();
        test_rr_stall();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
